// File: rtl/pipemem_lsu_if.sv
// Data-memory bus between the MEM-stage load/store unit (master) and memory (slave).
// Single outstanding access: req held until a one-cycle ack.
interface pipemem_lsu_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/pipemem_lsu.sv
// MIPS32 memory-stage load/store unit: lane steering, load extension, pipeline stall.
// Define PIPEMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning them down.
module pipemem_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [1:0]  msize,
  input  logic        munsigned,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  pipemem_lsu_if.master bus,
  output logic [31:0] mmo,
  output logic        mstall,
  output logic        maddr_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state;
  logic [1:0]  req_size;
  logic [1:0]  req_lo;
  logic        req_unsigned;
  logic        req_load;

  logic        mem_op;
  logic        issue;
  logic [1:0]  lo;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  assign mem_op = mwmem | mm2reg;

`ifdef PIPEMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((msize == 2'b01) && malu[0]) ||
                      (msize[1] && (malu[1:0] != 2'b00));
  assign issue = mem_op & ~misaligned;
`else
  assign issue = mem_op;
  assign maddr_err = 1'b0;
`endif

  // Low address bits are forced to the access size's alignment before lane selection.
  always_comb begin
    lo         = 2'b00;
    be_next    = 4'b1111;
    wdata_next = mb;
    case (msize)
      2'b00: begin
        lo         = malu[1:0];
        be_next    = 4'b0001 << malu[1:0];
        wdata_next = {4{mb[7:0]}};
      end
      2'b01: begin
        lo         = {malu[1], 1'b0};
        be_next    = malu[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{mb[15:0]}};
      end
      default: begin
        lo         = 2'b00;
        be_next    = 4'b1111;
        wdata_next = mb;
      end
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] d, input logic [1:0] sz,
                                           input logic [1:0] l, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (l)
      2'b00:   b = d[7:0];
      2'b01:   b = d[15:8];
      2'b10:   b = d[23:16];
      default: b = d[31:24];
    endcase
    h = l[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   fmt_load = {{24{~uns & b[7]}}, b};
      2'b01:   fmt_load = {{16{~uns & h[15]}}, h};
      default: fmt_load = d;
    endcase
  endfunction

  // The issue cycle stalls combinationally; the request itself only appears from BUSY.
  assign mstall = ~reset & (((state == IDLE) & issue) | (state == BUSY));

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'h0;
      bus.mem_be    <= 4'h0;
      bus.mem_wdata <= 32'h0;
      mmo           <= 32'h0;
      req_size      <= 2'b00;
      req_lo        <= 2'b00;
      req_unsigned  <= 1'b0;
      req_load      <= 1'b0;
`ifdef PIPEMEM_MISALIGN_TRAP_EN
      maddr_err     <= 1'b0;
`endif
    end else begin
`ifdef PIPEMEM_MISALIGN_TRAP_EN
      maddr_err <= (state == IDLE) && mem_op && misaligned;
`endif
      case (state)
        IDLE: begin
          if (issue) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= mwmem;
            bus.mem_addr  <= {malu[31:2], 2'b00};
            bus.mem_be    <= be_next;
            bus.mem_wdata <= wdata_next;
            req_size      <= msize;
            req_lo        <= lo;
            req_unsigned  <= munsigned;
            req_load      <= mm2reg & ~mwmem;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (req_load)
              mmo <= fmt_load(bus.mem_rdata, req_size, req_lo, req_unsigned);
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipemem_lsu.sv
// Self-checking bench for pipemem_lsu: table-driven loads/stores with a scoreboard,
// plus hand sequences for reset mid-transfer, back-to-back ops and misalignment.
module tb_pipemem_lsu;

  typedef struct {
    logic        wmem;
    logic        m2reg;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] alu;
    logic [31:0] mb;
    logic [31:0] rdata;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_mmo;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] mmo;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        mwmem;
  logic        mm2reg;
  logic [1:0]  msize;
  logic        munsigned;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] mmo;
  logic        mstall;
  logic        maddr_err;

  pipemem_lsu_if bus();

  pipemem_lsu dut (
    .clock(clock), .reset(reset), .mwmem(mwmem), .mm2reg(mm2reg), .msize(msize),
    .munsigned(munsigned), .malu(malu), .mb(mb), .bus(bus), .mmo(mmo),
    .mstall(mstall), .maddr_err(maddr_err)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          req_cycle = 0;
  logic [31:0] model_mmo = 32'h0;
  vec_t        vecs[$];
  exp_t        sb[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [1:0] sz, input logic u,
                              input logic [31:0] alu, input logic [31:0] d, input logic [31:0] rd,
                              input int dly, input logic [31:0] ea, input logic [3:0] eb,
                              input logic [31:0] ew, input logic [31:0] em);
    vec_t v;
    v.wmem = w; v.m2reg = r; v.size = sz; v.uns = u; v.alu = alu; v.mb = d; v.rdata = rd;
    v.delay = dly; v.exp_addr = ea; v.exp_be = eb; v.exp_wdata = ew; v.exp_mmo = em;
    return v;
  endfunction

  task automatic clearInputs();
    mwmem = 1'b0; mm2reg = 1'b0; msize = 2'b00; munsigned = 1'b0; malu = 32'h0; mb = 32'h0;
  endtask

  // Drives one op in its IDLE cycle, acks in the delay-th BUSY cycle, checks through DONE.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    int   stall_cnt;
    logic is_store;
    @(negedge clock);
    mwmem = v.wmem; mm2reg = v.m2reg; msize = v.size; munsigned = v.uns;
    malu = v.alu; mb = v.mb; bus.mem_rdata = v.rdata;
    is_store = v.wmem;
    if (!is_store) model_mmo = v.exp_mmo;
    e.we = is_store; e.addr = v.exp_addr; e.be = v.exp_be; e.wdata = v.exp_wdata; e.mmo = model_mmo;
    sb.push_back(e);
    #1;
    checkOutput("issue_req_low", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("issue_stall", {31'h0, mstall}, 32'h1);
    stall_cnt = mstall ? 1 : 0;
    for (int c = 1; c <= v.delay; c++) begin
      @(negedge clock);
      #1;
      if (c == 1) begin
        e = sb.pop_front();
        req_cycle = cyc;
        checkOutput("busy_req", {31'h0, bus.mem_req}, 32'h1);
        checkOutput("busy_we", {31'h0, bus.mem_we}, {31'h0, e.we});
        checkOutput("busy_addr", bus.mem_addr, e.addr);
        checkOutput("busy_be", {28'h0, bus.mem_be}, {28'h0, e.be});
        if (e.we) checkOutput("busy_wdata", bus.mem_wdata, e.wdata);
      end else begin
        checkOutput("busy_req_hold", {31'h0, bus.mem_req}, 32'h1);
        checkOutput("busy_addr_hold", bus.mem_addr, e.addr);
      end
      if (mstall) stall_cnt++;
      if (c == v.delay) bus.mem_ack = 1'b1;
    end
    @(negedge clock);
    bus.mem_ack = 1'b0;
    #1;
    checkOutput("done_stall", {31'h0, mstall}, 32'h0);
    checkOutput("done_req", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("done_mmo", mmo, e.mmo);
    checkOutput("stall_cycles", stall_cnt, v.delay + 1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r1;
    reset = 1'b1; bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    clearInputs();

    //             w  r  sz    u  alu          mb           rdata        dly addr         be       wdata        mmo
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 32'h100, 4'b1111, 32'h0,        32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h103, 32'h0,        32'h80112233, 1, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(0, 1, 2'b00, 1, 32'h103, 32'h0,        32'h80112233, 2, 32'h100, 4'b1000, 32'h0,        32'h00000080));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h102, 32'h0,        32'h80112233, 1, 32'h100, 4'b1100, 32'h0,        32'hFFFF8011));
    vecs.push_back(mk(0, 1, 2'b01, 1, 32'h100, 32'h0,        32'h1234F00D, 1, 32'h100, 4'b0011, 32'h0,        32'h0000F00D));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h101, 32'h0,        32'h80112233, 2, 32'h100, 4'b0010, 32'h0,        32'h00000022));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h201, 32'h000000A5, 32'h0,        1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h202, 32'h00001234, 32'h0,        2, 32'h200, 4'b1100, 32'h12341234, 32'h0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h304, 32'hCAFEF00D, 32'hFFFFFFFF, 4, 32'h304, 4'b1111, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h308, 32'h11223344, 32'h77777777, 1, 32'h308, 4'b1111, 32'h11223344, 32'h0));
    vecs.push_back(mk(0, 1, 2'b11, 1, 32'h10C, 32'h0,        32'h55AA55AA, 1, 32'h10C, 4'b1111, 32'h0,        32'h55AA55AA));
`ifndef PIPEMEM_MISALIGN_TRAP_EN
    // Misaligned accesses are aligned down when trapping is disabled.
    vecs.push_back(mk(0, 1, 2'b10, 0, 32'h102, 32'h0,        32'h01020304, 1, 32'h100, 4'b1111, 32'h0,        32'h01020304));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h203, 32'h0000BEEF, 32'h0,        1, 32'h200, 4'b1100, 32'hBEEFBEEF, 32'h0));
`endif

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("rst_req", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("rst_we", {31'h0, bus.mem_we}, 32'h0);
    checkOutput("rst_addr", bus.mem_addr, 32'h0);
    checkOutput("rst_be", {28'h0, bus.mem_be}, 32'h0);
    checkOutput("rst_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_mmo", mmo, 32'h0);
    checkOutput("rst_stall", {31'h0, mstall}, 32'h0);
    checkOutput("rst_err", {31'h0, maddr_err}, 32'h0);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] back-to-back loads with immediate ack");
    applyStimulus(mk(0, 1, 2'b10, 0, 32'h500, 32'h0, 32'hA0A0A0A0, 1, 32'h500, 4'b1111, 32'h0, 32'hA0A0A0A0));
    r1 = req_cycle;
    applyStimulus(mk(0, 1, 2'b10, 0, 32'h504, 32'h0, 32'h0B0B0B0B, 1, 32'h504, 4'b1111, 32'h0, 32'h0B0B0B0B));
    checkOutput("b2b_req_spacing", req_cycle - r1, 3);

`ifdef PIPEMEM_MISALIGN_TRAP_EN
    $display("[TB] misaligned word load traps");
    @(negedge clock);
    mm2reg = 1'b1; msize = 2'b10; malu = 32'h102;
    #1;
    checkOutput("mis_stall", {31'h0, mstall}, 32'h0);
    @(negedge clock);
    clearInputs();
    #1;
    checkOutput("mis_no_req", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("mis_err_pulse", {31'h0, maddr_err}, 32'h1);
    checkOutput("mis_mmo_kept", mmo, model_mmo);
    @(negedge clock);
    #1;
    checkOutput("mis_err_clear", {31'h0, maddr_err}, 32'h0);
    checkOutput("mis_no_req2", {31'h0, bus.mem_req}, 32'h0);
`endif

    $display("[TB] reset during BUSY, then late ack");
    @(negedge clock);
    mm2reg = 1'b1; msize = 2'b10; malu = 32'h600; bus.mem_rdata = 32'h12345678;
    @(negedge clock);
    #1;
    checkOutput("rb_req_high", {31'h0, bus.mem_req}, 32'h1);
    reset = 1'b1;
    clearInputs();
    @(negedge clock);
    reset = 1'b0;
    bus.mem_ack = 1'b1;
    #1;
    checkOutput("rb_req", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("rb_stall", {31'h0, mstall}, 32'h0);
    checkOutput("rb_mmo", mmo, 32'h0);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    #1;
    checkOutput("late_ack_req", {31'h0, bus.mem_req}, 32'h0);
    checkOutput("late_ack_stall", {31'h0, mstall}, 32'h0);
    checkOutput("late_ack_mmo", mmo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipemem_lsu.md
# pipemem_lsu

Memory-stage load/store unit of the 5-stage MIPS32 pipeline. Consumes the EX/MEM register outputs: the ALU result (address), the store operand and the memory control bits, which the execute stage computes and the EX/MEM register latches. Drives a single-outstanding req/ack data-memory bus, performs byte/halfword/word lane steering and load extension, and stalls the pipeline until the access completes. The formatted load data (`mmo`) feeds the MEM/WB register.

## Interface

- No parameters; bus width fixed at 32.

Ports:
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mwmem`  in  1  store instruction in MEM.
- `mm2reg`  in  1  load instruction in MEM.
- `msize`  in  2  access size: 00 byte, 01 halfword, 10 word; 11 treated as word.
- `munsigned`  in  1  zero-extend loads (LBU/LHU) when 1, else sign-extend.
- `malu`  in  32  effective address.
- `mb`  in  32  store data (right-aligned).
- `mem_rdata`  in  32  bus read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  bus completion, one-cycle pulse.
- `mem_req`  out  1  bus request, held until ack.
- `mem_we`  out  1  write enable, valid with `mem_req`.
- `mem_addr`  out  32  word address ({addr[31:2],2'b00}).
- `mem_be`  out  4  byte enables, little-endian lanes.
- `mem_wdata`  out  32  lane-replicated store data.
- `mmo`  out  32  formatted load data for the MEM/WB register.
- `mstall`  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
- `maddr_err`  out  1  misaligned access flag (see Configuration).

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: if (`mwmem`|`mm2reg`) and aligned, latch address, we, be, wdata, size, unsigned into request registers; next state BUSY. `mstall`=1 combinationally in this cycle. Non-memory instruction: `mstall`=0, stay IDLE.
- BUSY: `mem_req`=1, request registers stable; `mstall`=1. On `mem_ack`: for loads, latch formatted `mem_rdata` into `mmo`; next state DONE. No ack: remain BUSY indefinitely.
- DONE: `mstall`=0 for exactly one cycle so the pipeline advances; next state IDLE unconditionally. `mmo` holds until the next load completes.
- `mwmem` and `mm2reg` both high: treated as store; `mmo` unchanged.
- Store lanes: byte → `mem_wdata`={4{mb[7:0]}}, `mem_be`=0001<<addr[1:0]; halfword → {2{mb[15:0]}}, `mem_be`=addr[1]?1100:0011; word → `mb`, 1111.
- Load formatting: byte lane addr[1:0], halfword lane addr[1], extended to 32 bits per `munsigned`; word passes through.
- `mem_req` is driven only from state BUSY, never combinationally from inputs.
- Reset (any state, including BUSY mid-transfer): state→IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, `mmo`=0, `maddr_err`=0, `mstall`=0. A late `mem_ack` arriving in IDLE is ignored.

## Timing

- Latency, memory op issued in cycle T: `mem_req` high from T+1; ack in cycle T+k (k≥1) → DONE in T+k+1; `mstall` high cycles T..T+k; pipeline advances at end of T+k+1.
- Minimum occupancy 3 cycles (ack in first BUSY cycle); `mmo` valid from T+k+1.
- Back-to-back memory ops: second enters IDLE at T+k+2; no overlap, one outstanding access maximum.

## Configuration

- `PIPEMEM_MISALIGN_TRAP_EN` defined: misaligned access (halfword with addr[0]=1, word with addr[1:0]≠0) issues no bus request, `mstall`=0, `maddr_err` is a registered one-cycle pulse in the cycle after detection, `mmo` unchanged; state stays IDLE.
- Not defined: misaligned addresses are aligned down (low bits forced to 0 for the size) and the access proceeds normally; `maddr_err` tied 0.

## Test plan

- Reset while BUSY with `mem_req`=1 → next cycle `mem_req`=0, `mstall`=0, `mmo`=0, state IDLE; ack one cycle later has no effect.
- LW `malu`=0x100, ack after 3 BUSY cycles, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_be`=1111, `mstall` high 4 cycles, `mmo`=0xDEADBEEF in DONE.
- LB `malu`=0x103, `mem_rdata`=0x80112233 → `mmo`=0xFFFFFF80; LBU same → 0x00000080; LH `malu`=0x102 → 0xFFFF8011.
- SB `malu`=0x201, `mb`=0x000000A5 → `mem_we`=1, `mem_addr`=0x200, `mem_be`=0010, `mem_wdata`=0xA5A5A5A5; SH `malu`=0x202, `mb`=0x1234 → `mem_be`=1100, `mem_wdata`=0x12341234.
- Two consecutive LW with immediate ack → each occupies 3 cycles, second `mem_req` rises exactly 3 cycles after the first, no req/ack overlap.
- LW `malu`=0x102: with macro → no `mem_req`, `maddr_err` pulses 1 cycle, `mstall`=0; without → `mem_addr`=0x100, `mem_be`=1111, normal completion.
